// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU request scheduler: op encodings,
// FSM states and response flag layout.
package alu_ctrl_pkg;

  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_NOTA = 2;
  localparam int OP_NOR  = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_NAND = 5;
  localparam int OP_LAST = OP_NAND;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int FLAG_W    = 4;
  localparam int FLAG_COUT = 3;
  localparam int FLAG_NEG  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OVF  = 0;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; ptr names the requester preferred on a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       update,
  output logic [1:0] grant,
  output logic       ptr_next
);

  always_comb begin
    grant    = (req == 2'b11) ? (ptr ? 2'b10 : 2'b01) : req;
    ptr_next = ptr;
    // After serving requester N, prefer the other one next time.
    if (update && (grant != 2'b00)) begin
      ptr_next = grant[0];
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one combinational ALU between two requesters: round-robin grant,
// registered ALU operands, captured result returned on a tagged response.
module alu_req_scheduler
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req0_cin,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic              req1_cin,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  output logic              alu_cin,
  input  logic [WIDTH-1:0]  alu_y,
  input  logic              alu_cout,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_y,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on anything but state and the valids.
  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
  logic               alu_cin_q, alu_cin_d;
  logic               rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_y_q, rsp_y_d;
  logic [FLAG_W-1:0]  rsp_flags_q, rsp_flags_d;
  logic               rsp_err_q, rsp_err_d;

  logic [1:0]         arb_req, grant;
  logic               accept;
  logic [WIDTH-1:0]   win_a, win_b;
  logic [SEL_W-1:0]   win_sel;
  logic               win_cin;

  // The pointer moves at accept; it is only consulted in IDLE, which is not
  // revisited until the response handshake, so the effect is the same.
  assign arb_req = (state_q == ST_IDLE) ? {req1_valid, req0_valid} : 2'b00;

  rr_arb2 u_arb (
    .req      (arb_req),
    .ptr      (ptr_q),
    .update   (accept),
    .grant    (grant),
    .ptr_next (ptr_d)
  );

  assign accept     = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign win_a      = grant[1] ? req1_a   : req0_a;
  assign win_b      = grant[1] ? req1_b   : req0_b;
  assign win_sel    = grant[1] ? req1_sel : req0_sel;
  assign win_cin    = grant[1] ? req1_cin : req0_cin;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    alu_cin_d   = alu_cin_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rsp_id_d = grant[1];
          if (int'(win_sel) <= OP_LAST) begin
            alu_a_d   = win_a;
            alu_b_d   = win_b;
            alu_sel_d = win_sel;
            alu_cin_d = win_cin;
            state_d   = ST_EXEC;
          end else begin
            rsp_err_d   = 1'b1;
            rsp_y_d     = '0;
            rsp_flags_d = '0;
            state_d     = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        rsp_y_d                = alu_y;
        rsp_flags_d            = '0;
        rsp_flags_d[FLAG_COUT] = alu_cout;
        rsp_flags_d[FLAG_NEG]  = alu_negative;
        rsp_flags_d[FLAG_ZERO] = alu_zero;
        rsp_flags_d[FLAG_OVF]  = alu_overflow;
        rsp_err_d              = 1'b0;
        state_d                = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      alu_cin_q   <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      alu_cin_q   <= alu_cin_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign alu_cin   = alu_cin_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Self-checking bench for alu_req_scheduler: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_alu_req_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin, req1_valid, req1_ready, req1_cin;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_sel, req1_sel;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_sel;
  logic        alu_cin, alu_cout, alu_negative, alu_zero, alu_overflow;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_y;
  logic [3:0]  rsp_flags;

  int total = 0;
  int bad   = 0;

  logic        flag_force = 1'b0;
  logic [3:0]  forced_flags = 4'b0000;
  logic [35:0] alu_res;
  logic [37:0] exp_q[$];

  always #5 clk = ~clk;

  alu_req_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel), .req1_cin(req1_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_negative(alu_negative),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  // Behavioural ALU: returns {cout, negative, zero, overflow, y}.
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] s);
    logic [31:0] y;
    case (s)
      4'd0:    y = a & b;
      4'd1:    y = a | b;
      4'd2:    y = ~a;
      4'd3:    y = ~(a | b);
      4'd4:    y = a ^ b;
      4'd5:    y = ~(a & b);
      default: y = 32'd0;
    endcase
    return {1'b0, y[31], (y == 32'd0), 1'b0, y};
  endfunction

  always_comb begin
    alu_res = alu_ref(alu_a, alu_b, alu_sel);
    alu_y   = alu_res[31:0];
    {alu_cout, alu_negative, alu_zero, alu_overflow} = flag_force ? forced_flags : alu_res[35:32];
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_sel = '0; req0_cin = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_sel = '0; req1_cin = 0;
    rsp_ready  = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic drive_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] s, input logic c);
    if (id == 0) begin
      req0_valid = 1; req0_a = a; req0_b = b; req0_sel = s; req0_cin = c;
    end else begin
      req1_valid = 1; req1_a = a; req1_b = b; req1_sel = s; req1_cin = c;
    end
  endtask

  task automatic wait_rsp(input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      if (rsp_valid) ok = 1;
      else step();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if ({req1_ready, req0_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready}); end
    total++; if ({rsp_id, rsp_err, rsp_flags, rsp_y} !== 38'd0) begin bad++; $display("FAIL reset_rsp_fields: got %h want 0", {rsp_id, rsp_err, rsp_flags, rsp_y}); end
    total++; if ({alu_a, alu_b, alu_sel, alu_cin} !== 69'd0) begin bad++; $display("FAIL reset_alu: got %h want 0", {alu_a, alu_b, alu_sel, alu_cin}); end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_single_and();
    bit ok;
    apply_reset();
    drive_req(0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd0, 1'b1);
    #1;
    total++; if ({req1_ready, req0_ready} !== 2'b01) begin bad++; $display("FAIL and_grant: got %b want 01", {req1_ready, req0_ready}); end
    step();
    req0_valid = 0;
    total++; if ({alu_a, alu_b, alu_sel, alu_cin} !== {32'hF0F0F0F0, 32'hFF00FF00, 4'd0, 1'b1}) begin bad++; $display("FAIL and_alu_regs: got %h want %h", {alu_a, alu_b, alu_sel, alu_cin}, {32'hF0F0F0F0, 32'hFF00FF00, 4'd0, 1'b1}); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL and_early_rsp: got %b want 0", rsp_valid); end
    step();
    ok = rsp_valid;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL and_latency: rsp_valid got %b want 1", ok); end
    total++; if ({rsp_id, rsp_err, rsp_y} !== {1'b0, 1'b0, 32'hF000F000}) begin bad++; $display("FAIL and_rsp: got %h want %h", {rsp_id, rsp_err, rsp_y}, {1'b0, 1'b0, 32'hF000F000}); end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL and_rsp_clear: got %b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    int n = 0;
    apply_reset();
    drive_req(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 1'b0);
    drive_req(1, 32'h0, 32'h0, 4'd1, 1'b0);
    rsp_ready = 1;
    for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
      if (rsp_valid) begin
        total++; if (rsp_id !== n[0]) begin bad++; $display("FAIL rr_id[%0d]: got %b want %b", n, rsp_id, n[0]); end
        total++; if ({rsp_flags[1], rsp_y} !== {1'b1, 32'h0}) begin bad++; $display("FAIL rr_zero[%0d]: flags %b y %h want zero flag and y=0", n, rsp_flags, rsp_y); end
        n++;
      end
      step();
    end
    total++; if (n != 4) begin bad++; $display("FAIL rr_timeout: got %0d responses want 4", n); end
    req0_valid = 0; req1_valid = 0;
    repeat (5) step();
    rsp_ready = 0;
  endtask

  task automatic test_back_pressure();
    bit ok;
    logic [37:0] snap;
    apply_reset();
    drive_req(0, 32'h12345678, 32'h0F0F0F0F, 4'd0, 1'b0);
    step();
    req0_valid = 0;
    drive_req(1, 32'hAAAA5555, 32'h0000FFFF, 4'd1, 1'b0);
    wait_rsp(10, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_rsp_timeout: rsp_valid got 0 want 1"); end
    snap = {rsp_id, rsp_err, rsp_flags, rsp_y};
    total++; if (snap !== {1'b0, 1'b0, 4'b0000, 32'h02040608}) begin bad++; $display("FAIL bp_rsp: got %h want %h", snap, {1'b0, 1'b0, 4'b0000, 32'h02040608}); end
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if ({rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_y} !== {1'b1, snap}) begin bad++; $display("FAIL bp_hold[%0d]: got %h want %h", i, {rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_y}, {1'b1, snap}); end
      total++; if ({req1_ready, req0_ready} !== 2'b00) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 00", i, {req1_ready, req0_ready}); end
    end
    rsp_ready = 1;
    #1;
    total++; if ({req1_ready, req0_ready} !== 2'b00) begin bad++; $display("FAIL bp_hs_ready: got %b want 00", {req1_ready, req0_ready}); end
    step();
    rsp_ready = 0;
    total++; if ({req1_ready, req0_ready} !== 2'b10) begin bad++; $display("FAIL bp_next_accept: got %b want 10", {req1_ready, req0_ready}); end
    step();
    req1_valid = 0;
    wait_rsp(10, ok);
    total++; if ({ok, rsp_id, rsp_y} !== {1'b1, 1'b1, 32'hAAAAFFFF}) begin bad++; $display("FAIL bp_second: got %h want %h", {ok, rsp_id, rsp_y}, {1'b1, 1'b1, 32'hAAAAFFFF}); end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
  endtask

  task automatic test_illegal_sel();
    drive_req(1, 32'hDEADBEEF, 32'h1, 4'd9, 1'b1);
    #1;
    total++; if ({req1_ready, req0_ready} !== 2'b10) begin bad++; $display("FAIL ill_grant: got %b want 10", {req1_ready, req0_ready}); end
    step();
    req1_valid = 0;
    total++; if ({rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_y} !== {1'b1, 1'b1, 1'b1, 4'b0, 32'h0}) begin bad++; $display("FAIL ill_rsp: got %h want %h", {rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_y}, {1'b1, 1'b1, 1'b1, 4'b0, 32'h0}); end
    total++; if ({alu_sel, alu_a} !== {4'd1, 32'hAAAA5555}) begin bad++; $display("FAIL ill_alu_kept: got %h want %h", {alu_sel, alu_a}, {4'd1, 32'hAAAA5555}); end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    drive_req(0, 32'h1, 32'h2, 4'd4, 1'b0);
    step();
    req0_valid = 0;
    #1;
    rst_n = 0;
    #1;
    total++; if ({rsp_valid, alu_a, alu_b, alu_sel, alu_cin} !== 70'd0) begin bad++; $display("FAIL midrst_outputs: got %h want 0", {rsp_valid, alu_a, alu_b, alu_sel, alu_cin}); end
    @(negedge clk);
    rst_n = 1;
    step();
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_ghost[%0d]: rsp_valid got %b want 0", i, rsp_valid); end
      step();
    end
    rsp_ready = 0;
    drive_req(1, 32'h7, 32'h3, 4'd5, 1'b0);
    #1;
    total++; if ({req1_ready, req0_ready} !== 2'b10) begin bad++; $display("FAIL midrst_grant: got %b want 10", {req1_ready, req0_ready}); end
    step();
    req1_valid = 0;
    wait_rsp(10, ok);
    total++; if ({ok, rsp_id, rsp_y} !== {1'b1, 1'b1, 32'hFFFFFFFC}) begin bad++; $display("FAIL midrst_rsp: got %h want %h", {ok, rsp_id, rsp_y}, {1'b1, 1'b1, 32'hFFFFFFFC}); end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
  endtask

  task automatic test_flags();
    bit ok;
    flag_force = 1; forced_flags = 4'b1010;
    drive_req(0, 32'h5, 32'h3, 4'd1, 1'b0);
    step();
    req0_valid = 0;
    wait_rsp(10, ok);
    total++; if ({ok, rsp_flags, rsp_y} !== {1'b1, 4'b1010, 32'h7}) begin bad++; $display("FAIL flags_pass: got %h want %h", {ok, rsp_flags, rsp_y}, {1'b1, 4'b1010, 32'h7}); end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    flag_force = 0;
  endtask

  // Transaction-level model: one job in flight at a time; a tie goes to the
  // requester not served last; each response matches the oldest accepted job.
  task automatic test_random();
    logic [31:0] fa[2], fb[2];
    logic [3:0]  fs[2];
    logic        fc[2];
    bit          pend[2];
    bit          busy = 0, pref = 0, done = 0, served = 0;
    logic [1:0]  exp_g, acc;
    logic        rsp_hs;
    logic [35:0] r;
    logic [37:0] e;
    int          cyc = 0;
    apply_reset();
    exp_q.delete();
    pend[0] = 0; pend[1] = 0;
    while (cyc < 900 && !done) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && cyc < 600 && $urandom_range(0, 1) == 1) begin
          fa[i] = $urandom; fb[i] = $urandom; fc[i] = 1'($urandom_range(0, 1));
          fs[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
          pend[i] = 1;
        end
      end
      req0_valid = pend[0]; req0_a = fa[0]; req0_b = fb[0]; req0_sel = fs[0]; req0_cin = fc[0];
      req1_valid = pend[1]; req1_a = fa[1]; req1_b = fb[1]; req1_sel = fs[1]; req1_cin = fc[1];
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_g = 2'b00;
      if (!busy) exp_g = (pend[0] && pend[1]) ? (pref ? 2'b10 : 2'b01) : {pend[1], pend[0]};
      total++; if ({req1_ready, req0_ready} !== exp_g) begin bad++; $display("FAIL rand_grant@%0d: got %b want %b", cyc, {req1_ready, req0_ready}, exp_g); end
      acc = {req1_valid & req1_ready, req0_valid & req0_ready};
      rsp_hs = rsp_valid & rsp_ready;
      if (rsp_hs) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_unexpected_rsp@%0d: got id %b y %h want no response", cyc, rsp_id, rsp_y);
        end else begin
          e = exp_q.pop_front();
          served = e[37];
          if ({rsp_id, rsp_err, rsp_flags, rsp_y} !== e) begin bad++; $display("FAIL rand_rsp@%0d: got %h want %h", cyc, {rsp_id, rsp_err, rsp_flags, rsp_y}, e); end
        end
      end
      step();
      if (acc != 2'b00) begin
        served = acc[1];
        r = alu_ref(fa[served], fb[served], fs[served]);
        if (fs[served] > 4'd5) exp_q.push_back({served, 1'b1, 4'b0, 32'h0});
        else                   exp_q.push_back({served, 1'b0, r[35:32], r[31:0]});
        pend[served] = 0;
        busy = 1;
      end
      if (rsp_hs) begin
        busy = 0;
        pref = ~served;
      end
      cyc++;
      done = (cyc >= 600) && !busy && !pend[0] && !pend[1] && (exp_q.size() == 0);
    end
    total++; if (!done) begin bad++; $display("FAIL rand_drain: got %0d outstanding want 0", exp_q.size()); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_and();
    test_round_robin();
    test_back_pressure();
    test_illegal_sel();
    test_reset_mid();
    test_flags();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_req_scheduler.md
# alu_req_scheduler

Shares one combinational ALU between two requesters. Each requester presents an operation (operands, `sel`, `Cin`) with a valid/ready handshake. The block grants one request at a time in round-robin order, registers the operands onto the ALU inputs, captures the ALU result and flags, and returns a tagged response on a single response channel. It sits between the two issuing units and the ALU datapath.

## Interface
- `WIDTH`, 32, operand/result width
- `SEL_W`, 4, operation select width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req0_valid` / `req1_valid` in 1: request present
- `req0_ready` / `req1_ready` out 1: request accepted this cycle
- `req0_a`, `req0_b` / `req1_a`, `req1_b` in WIDTH: operands
- `req0_sel` / `req1_sel` in SEL_W: operation
- `req0_cin` / `req1_cin` in 1: carry-in
- `alu_a`, `alu_b` out WIDTH: registered ALU operands
- `alu_sel` out SEL_W: registered ALU select
- `alu_cin` out 1: registered ALU carry-in
- `alu_y` in WIDTH: ALU result
- `alu_cout`, `alu_negative`, `alu_zero`, `alu_overflow` in 1: ALU flags
- `rsp_valid` out 1: response present
- `rsp_ready` in 1: response consumed
- `rsp_id` out 1: requester index of response
- `rsp_y` out WIDTH: captured result
- `rsp_flags` out 4: {cout, negative, zero, overflow}
- `rsp_err` out 1: illegal `sel` (values 6–15)

## Operation
- Legal `sel` encodings: 0 AND, 1 OR, 2 NOT(A), 3 NOR, 4 XOR, 5 NAND.
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `reqN_valid` is high, the arbiter picks a winner. Only the winner's `ready` is driven high (combinationally) in this cycle.
  - On the handshake, latch the winner's id.
  - If `sel` ≤ 5: load `alu_*` from the winner's fields and go to EXEC.
  - Otherwise: set `rsp_err`=1, `rsp_y`=0, `rsp_flags`=0, leave `alu_*` unchanged, and go to RESP.
- **EXEC** (one cycle): capture `alu_y` and the flags into the `rsp_*` registers, set `rsp_err`=0, and go to RESP.
- **RESP**: hold `rsp_valid`=1 until `rsp_ready`. On the handshake, go to IDLE and set the round-robin pointer to prefer the requester that was *not* just served.
- Round-robin:
  - When both requesters are valid, the preferred one wins.
  - When one is valid, it wins regardless of the pointer.
  - After reset, req0 is preferred.
- Both `reqN_ready` outputs are 0 in EXEC and RESP. A requester must hold its fields stable while valid and not ready.
- The `rsp_*` fields are stable while `rsp_valid`=1 and `rsp_ready`=0.

## Timing
- Reset (asynchronous, on `rst_n` low):
  - State: IDLE. Pointer: req0.
  - `req*_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_y`=0, `rsp_flags`=0, `rsp_err`=0.
  - `alu_a`, `alu_b`=0; `alu_sel`=0; `alu_cin`=0.
- Reset mid-operation discards the in-flight transaction; no response is issued.
- Legal-op latency: request accepted at edge E0 → `alu_*` valid after E0 → result captured at E1 → `rsp_valid` high after E1.
- Illegal-op latency: `rsp_valid` high after E0.
- With `rsp_ready` tied high, peak throughput is one legal op per 3 cycles. An illegal op takes 2 cycles.
- No request is accepted in the cycle of a response handshake. The next accept happens at the earliest in the following IDLE cycle.
- Simultaneous `req0_valid` and `req1_valid` in IDLE: exactly one `ready` is asserted, chosen by the pointer.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - `OP_AND`..`OP_NAND` sel constants and `OP_LAST`=5
  - the FSM state enum
  - `FLAG_W`=4 and flag bit positions
- Sub-module `rr_arb2`: 2-input round-robin arbiter.
  - Inputs: `req[1:0]`, pointer, `update` strobe.
  - Outputs: one-hot `grant`, updated pointer.

## Test plan
- **Single AND request.** req0: A=0xF0F0F0F0, B=0xFF00FF00, sel=0; bench uses a behavioural 32-bit ALU model. Expect `rsp_valid` 2 cycles after accept, `rsp_id`=0, `rsp_y`=0xF000F000, `rsp_err`=0.
- **Round-robin under contention.**
  - Both requesters valid continuously: req0 XOR A=0xFFFFFFFF, B=0xFFFFFFFF; req1 OR A=0, B=0.
  - Expect the `rsp_id` sequence 0,1,0,1.
  - Expect `rsp_flags` zero bit=1 on every response.
- **Response backpressure.** Hold `rsp_ready`=0 for 5 cycles. `rsp_*` must stay constant, and both `req*_ready` must stay 0. Release → the next accept occurs in the following IDLE cycle.
- **Illegal sel.** req1 sel=9. Expect `rsp_valid` 1 cycle after accept, `rsp_err`=1, `rsp_y`=0, `alu_sel` unchanged from the prior op.
- **Reset mid-operation.** Assert `rst_n`=0 during EXEC. Outputs are immediately at their reset values, and no response appears after release. A req1-only request after release is granted to req1.
- **Flag pass-through.** ALU model drives `alu_cout`=1, `alu_negative`=0, `alu_zero`=1, `alu_overflow`=0 in EXEC. Expect `rsp_flags`=4'b1010.
